ccff_loader: RTL and testbench

Configuration-chain loader for the eFPGA fabric. Accepts bitstream words from the host over a valid/ready stream and shifts them serially into the configuration flip-flop chain through `ccff_head`, one bit per enabled `prog_clk` cycle. It gates the chain clock through `ccff_clk_en`, which drives the fabric's prog-clock ICG. It also captures the bits falling out of `ccff_tail` and returns them as readback words, so the host can check chain integrity.

---
 rtl/ccff_loader_pkg.sv | 18 +
 rtl/ccff_readback_packer.sv | 62 ++++++
 rtl/ccff_loader.sv | 160 ++++++++++++++++
 tb/tb_ccff_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// ccff_loader shared types and defaults.
// Bitstream word type, chain-length defaults and the loader FSM states.
package ccff_loader_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 16;

    typedef logic [DATA_W_DEF-1:0] ccff_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } ccff_state_e;

endpackage

// File: rtl/ccff_readback_packer.sv
// Serial-to-parallel collector for bits leaving ccff_tail.
// Holds one finished word in rb_data and stalls the chain when it cannot accept another.
module ccff_readback_packer
    import ccff_loader_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    localparam int POS_W  = $clog2(DATA_W)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              clear,
    input  logic              flush,
    input  logic              shift_req,
    input  logic              last_bit,
    input  logic [POS_W-1:0]  pos,
    input  logic              tail,
    input  logic              rb_ready,
    output logic              stall,
    output logic              coll_pend,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_valid
);

    logic [DATA_W-1:0] coll;
    logic [DATA_W-1:0] word;
    logic              completes;
    logic              adv;

    // The final bit closes a word early; unused upper bits stay zero.
    assign completes = (pos == POS_W'(DATA_W - 1)) || last_bit;
    assign stall     = shift_req && completes && rb_valid && !rb_ready;
    assign adv       = shift_req && !stall;
    assign word      = coll | (DATA_W'(tail) << pos);

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            coll      <= '0;
            coll_pend <= 1'b0;
        end else if (clear) begin
            coll      <= '0;
            coll_pend <= 1'b0;
        end else if (adv) begin
            coll      <= completes ? '0 : word;
            coll_pend <= !completes;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else if (flush) begin
            rb_valid <= 1'b0;
        end else if (adv && completes) begin
            rb_data  <= word;
            rb_valid <= 1'b1;
        end else if (rb_ready) begin
            rb_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: streams host words serially into the
// eFPGA config chain and returns the bits shifted out as readback words.
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  chain_len,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              busy,
    output logic              done,
    output logic              err_abort
);

    localparam int WL_W  = $clog2(DATA_W) + 1;
    localparam int POS_W = $clog2(DATA_W);

    ccff_state_e       state;
    ccff_state_e       state_nx;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  bit_cnt;
    logic [WL_W-1:0]   word_left;
    logic [DATA_W-1:0] sreg;
    logic              kill;
    logic              shift_req;
    logic              stall;
    logic              adv;
    logic              last_bit;
    logic              word_end;
    logic              accept;
    logic              coll_pend;

    assign kill      = abort && (state != ST_IDLE);
    assign accept    = start && (state == ST_IDLE);
    assign shift_req = (state == ST_SHIFT) && !abort;
    assign adv       = shift_req && !stall;
    assign last_bit  = (bit_cnt == len_q - LEN_W'(1));
    assign word_end  = (word_left == WL_W'(1));
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        s_ready     = 1'b0;
        ccff_clk_en = 1'b0;
        ccff_head   = 1'b0;
        done        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (chain_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ccff_head   = sreg[0];
                ccff_clk_en = !stall;
                if (!stall) begin
                    if (last_bit) begin
                        state_nx = ST_DRAIN;
                    end else if (word_end) begin
                        // Prefetch the next word so back-to-back words have no bubble.
                        s_ready = 1'b1;
                        if (!s_valid) begin
                            state_nx = ST_LOAD;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!coll_pend) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (kill) begin
            state_nx    = ST_IDLE;
            s_ready     = 1'b0;
            ccff_clk_en = 1'b0;
            done        = 1'b0;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            len_q     <= '0;
            bit_cnt   <= '0;
            word_left <= '0;
            sreg      <= '0;
            err_abort <= 1'b0;
        end else begin
            if (accept) begin
                len_q     <= chain_len;
                bit_cnt   <= '0;
                err_abort <= 1'b0;
            end else if (kill) begin
                err_abort <= 1'b1;
            end
            if (adv) begin
                bit_cnt <= bit_cnt + LEN_W'(1);
            end
            if (s_ready && s_valid) begin
                sreg      <= s_data;
                word_left <= WL_W'(DATA_W);
            end else if (adv) begin
                sreg      <= sreg >> 1;
                word_left <= word_left - WL_W'(1);
            end
        end
    end

    ccff_readback_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .prog_clk  (prog_clk),
        .pReset_n  (pReset_n),
        .clear     (accept),
        .flush     (kill),
        .shift_req (shift_req),
        .last_bit  (last_bit),
        .pos       (bit_cnt[POS_W-1:0]),
        .tail      (ccff_tail),
        .rb_ready  (rb_ready),
        .stall     (stall),
        .coll_pend (coll_pend),
        .rb_data   (rb_data),
        .rb_valid  (rb_valid)
    );

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: behavioural chain, word-level expectations,
// table vectors, hand-written corner cases and randomized loads.
module tb_ccff_loader;
    import ccff_loader_pkg::*;

    logic        prog_clk = 1'b0;
    logic        pReset_n;
    logic        start;
    logic [15:0] chain_len;
    logic        abort;
    ccff_word_t  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        ccff_head;
    logic        ccff_clk_en;
    logic        ccff_tail;
    ccff_word_t  rb_data;
    logic        rb_valid;
    logic        rb_ready;
    logic        busy;
    logic        done;
    logic        err_abort;

    ccff_loader dut (
        .prog_clk    (prog_clk),
        .pReset_n    (pReset_n),
        .start       (start),
        .chain_len   (chain_len),
        .abort       (abort),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .ccff_head   (ccff_head),
        .ccff_clk_en (ccff_clk_en),
        .ccff_tail   (ccff_tail),
        .rb_data     (rb_data),
        .rb_valid    (rb_valid),
        .rb_ready    (rb_ready),
        .busy        (busy),
        .done        (done),
        .err_abort   (err_abort)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        int         len;
        logic [31:0] w0;
        logic [31:0] w1;
        bit         zero_pre;
        int         en_exp;
        int         done_at;
    } vec_t;

    vec_t         tbl[5];
    int           n_vec = 0;
    int           n_bad = 0;
    logic [127:0] chain = '0;
    int           mlen = 32;
    logic [31:0]  wq[3];
    logic [31:0]  src_q[$];
    logic [31:0]  exp_q[$];
    logic [31:0]  rb_q[$];
    logic         head_q[$];
    bit           src_pop = 0;
    bit           s_gate = 1;
    bit           rb_rand = 0;
    bit           v_rand = 0;
    bit           rb_hold = 1;
    int           en_cnt = 0;
    int           done_cnt = 0;
    int           cyc = 0;
    int           first_en = 0;
    int           last_en = 0;
    int           done_cyc = 0;
    int           t0 = 0;
    int           d0 = 0;
    logic [127:0] pre;

    // Behavioural chain: index 0 is next to ccff_head, the tail is at mlen-1.
    assign ccff_tail = chain[7'(mlen - 1)];

    always @(posedge prog_clk) begin
        if (ccff_clk_en) chain <= {chain[126:0], ccff_head};
    end

    always @(negedge prog_clk) begin
        if (pReset_n) begin
            if (ccff_clk_en) begin
                head_q.push_back(ccff_head);
                if (en_cnt == 0) first_en = cyc;
                last_en = cyc;
                en_cnt++;
            end
            if (rb_valid && rb_ready) rb_q.push_back(rb_data);
            if (s_valid && s_ready) src_pop = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rb(input logic [127:0] p, input int len, input int j);
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) begin
            if (32 * j + i < len) w[i] = p[len - 1 - (32 * j + i)];
        end
        return w;
    endfunction

    task automatic step();
        @(posedge prog_clk);
        #1;
        if (src_pop) begin
            void'(src_q.pop_front());
            src_pop = 1'b0;
        end
        s_valid = s_gate && (src_q.size() > 0);
        s_data  = (src_q.size() > 0) ? src_q[0] : '0;
        if (v_rand && $urandom_range(0, 1) == 0) s_valid = 1'b0;
        rb_ready = rb_rand ? 1'($urandom_range(0, 1)) : rb_hold;
    endtask

    task automatic prep(input int len, input bit do_pre, input logic [127:0] p);
        head_q.delete();
        rb_q.delete();
        src_q.delete();
        exp_q.delete();
        en_cnt  = 0;
        src_pop = 1'b0;
        mlen    = len;
        if (do_pre) chain <= p;
        for (int j = 0; j < (len + 31) / 32; j++) begin
            src_q.push_back(wq[j]);
            exp_q.push_back(exp_rb(p, len, j));
        end
    endtask

    task automatic launch(input int len);
        d0        = done_cnt;
        start     = 1'b1;
        chain_len = 16'(len);
        t0        = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic finish(input int len, input int done_at, input bit poke);
        int k;
        int bad;
        logic [31:0] w;
        k = 0;
        while (done_cnt == d0 && k < 400) begin
            if (poke && k == 6) begin
                start     = 1'b1;
                chain_len = 16'd2;
            end else begin
                start = 1'b0;
            end
            step();
            k++;
        end
        start   = 1'b0;
        rb_rand = 0;
        v_rand  = 0;
        rb_hold = 1;
        repeat (3) step();
        chk("done_pulse", done_cnt - d0, 1);
        if (done_at >= 0) chk("done_cycle", done_cyc - t0, done_at);
        chk("enables", en_cnt, len);
        bad = 0;
        for (int b = 0; b < len; b++) begin
            w = wq[b / 32];
            if (b >= head_q.size() || head_q[b] !== w[b % 32]) bad++;
        end
        chk("head_stream", bad, 0);
        chk("rb_count", rb_q.size(), exp_q.size());
        for (int j = 0; j < rb_q.size() && j < exp_q.size(); j++)
            chk("rb_data", int'(rb_q[j]), int'(exp_q[j]));
        chk("src_empty", src_q.size(), 0);
        chk("busy_idle", int'(busy), 0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int k;
        int len;
        pReset_n  = 1'b0;
        start     = 1'b0;
        chain_len = '0;
        abort     = 1'b0;
        s_data    = '0;
        s_valid   = 1'b0;
        rb_ready  = 1'b1;

        tbl[0] = '{36, 32'hA5A5_A5A5, 32'h0000_000F, 1'b1, 36, 39};
        tbl[1] = '{32, 32'h1234_5678, 32'h0000_0000, 1'b0, 32, 35};
        tbl[2] = '{1,  32'h0000_0001, 32'h0000_0000, 1'b0, 1,  4};
        tbl[3] = '{33, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33, 36};
        tbl[4] = '{64, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 64, 67};

        #3;
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_head", int'(ccff_head), 0);
        chk("rst_clk_en", int'(ccff_clk_en), 0);
        chk("rst_rb_data", int'(rb_data), 0);
        chk("rst_rb_valid", int'(rb_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_abort), 0);
        step();
        pReset_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            wq[0] = tbl[i].w0;
            wq[1] = tbl[i].w1;
            wq[2] = '0;
            pre = tbl[i].zero_pre ? '0 : rnd128();
            prep(tbl[i].len, 1'b1, pre);
            launch(tbl[i].len);
            finish(tbl[i].len, tbl[i].done_at, 1'b0);
            chk("contiguous", last_en - first_en + 1, tbl[i].en_exp);
            chk("first_en", first_en - t0, 2);
        end

        // Round trip: the second pass reads back what the first one wrote.
        wq[0] = 32'h1234_5678;
        prep(32, 1'b1, rnd128());
        launch(32);
        finish(32, 35, 1'b0);
        prep(32, 1'b0, '0);
        exp_q.delete();
        exp_q.push_back(32'h1234_5678);
        launch(32);
        finish(32, 35, 1'b0);

        // Readback backpressure on the final word boundary.
        wq[0] = $urandom;
        wq[1] = $urandom;
        prep(64, 1'b1, rnd128());
        rb_hold = 0;
        launch(64);
        k = 0;
        while (en_cnt < 63 && k < 200) begin
            step();
            k++;
        end
        for (int i = 0; i < 6; i++) begin
            chk("bp_clk_en", int'(ccff_clk_en), 0);
            chk("bp_s_ready", int'(s_ready), 0);
            step();
        end
        chk("bp_held", en_cnt, 63);
        chk("bp_pending", int'(rb_valid), 1);
        rb_hold  = 1;
        rb_ready = 1'b1;
        finish(64, -1, 1'b0);

        // Input starvation between words.
        wq[0] = $urandom;
        wq[1] = $urandom;
        prep(64, 1'b1, rnd128());
        launch(64);
        k = 0;
        while (src_q.size() == 2 && k < 20) begin
            step();
            k++;
        end
        s_gate  = 0;
        s_valid = 1'b0;
        while (en_cnt < 32 && k < 100) begin
            step();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("starve_clk_en", int'(ccff_clk_en), 0);
            chk("starve_load", int'(s_ready), 1);
            if (i == 4) s_gate = 1;
            step();
        end
        chk("starve_cnt", en_cnt, 32);
        finish(64, 73, 1'b0);

        // Abort while shifting bit 10.
        wq[0] = $urandom;
        wq[1] = $urandom;
        prep(64, 1'b1, rnd128());
        launch(64);
        k = 0;
        while (en_cnt < 10 && k < 50) begin
            step();
            k++;
        end
        abort = 1'b1;
        #1;
        chk("abort_clk_en", int'(ccff_clk_en), 0);
        chk("abort_s_ready", int'(s_ready), 0);
        step();
        abort = 1'b0;
        chk("abort_idle", int'(busy), 0);
        chk("abort_err", int'(err_abort), 1);
        chk("abort_rb_valid", int'(rb_valid), 0);
        repeat (3) step();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_bits", en_cnt, 10);
        src_q.delete();
        src_pop = 1'b0;

        // Zero-length load: immediate done, clears the abort flag.
        d0        = done_cnt;
        start     = 1'b1;
        chain_len = '0;
        step();
        start = 1'b0;
        chk("zero_err_clr", int'(err_abort), 0);
        repeat (3) step();
        chk("zero_done", done_cnt - d0, 1);
        chk("zero_no_en", en_cnt, 10);

        // Asynchronous reset in the middle of a load.
        wq[0] = $urandom;
        wq[1] = $urandom;
        prep(64, 1'b1, rnd128());
        launch(64);
        k = 0;
        while (en_cnt < 5 && k < 50) begin
            step();
            k++;
        end
        #2;
        pReset_n = 1'b0;
        #1;
        chk("arst_clk_en", int'(ccff_clk_en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_s_ready", int'(s_ready), 0);
        step();
        pReset_n = 1'b1;
        src_q.delete();
        src_pop = 1'b0;
        step();

        // Randomized loads with random backpressure and starvation.
        for (int i = 0; i < 20; i++) begin
            len   = $urandom_range(1, 96);
            wq[0] = $urandom;
            wq[1] = $urandom;
            wq[2] = $urandom;
            prep(len, 1'b1, rnd128());
            rb_rand = 1;
            v_rand  = 1;
            launch(len);
            finish(len, -1, (i % 3 == 0) && (len >= 16));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
